// File: rtl/mem_ctrl.sv
// mem_ctrl: shares one byte-wide RAM port between an instruction-fetch (IF)
// port and a load/store (LS) port. Each port can hold one pending request;
// transfers of 1..4 bytes are serviced one at a time, with LS ahead of IF.
//
// Request/completion protocol (identical on both ports):
//   A request is a one-cycle pulse with rw_flag != 00 on an edge where rdy=1.
//   The port must not issue again while its busy output is high; such a
//   request is dropped without any state change. busy is high from the edge
//   after the request is taken until the edge that raises done. done is a
//   single-cycle pulse. For reads, the port's data output is updated in the
//   same cycle done is high and then stays stable until that port's next
//   read completes.
// The RAM model is expected to return the byte at the presented address one
// cycle later and to be stalled by the same rdy as this block.
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [1:0]  if_rw_flag,
    input  logic [31:0] if_addr,
    input  logic [1:0]  if_len,
    output logic [31:0] if_data,
    output logic        if_busy,
    output logic        if_done,
    input  logic [1:0]  ls_rw_flag,
    input  logic [31:0] ls_addr,
    input  logic [1:0]  ls_len,
    input  logic [31:0] ls_wdata,
    output logic [31:0] ls_data,
    output logic        ls_busy,
    output logic        ls_done,
    input  logic [7:0]  ram_din,
    output logic [7:0]  ram_dout,
    output logic [31:0] ram_addr,
    output logic        ram_wr,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    // Transfer engine
    logic [1:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        port_q, port_d;       // 1 = LS owns the transfer, 0 = IF
    logic [1:0]  len_q, len_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] buf_q, buf_d;         // read assembly buffer, little-endian

    // Per-port pending request
    logic        if_pend_q, if_pend_d;
    logic        if_pwr_q, if_pwr_d;
    logic [31:0] if_paddr_q, if_paddr_d;
    logic [1:0]  if_plen_q, if_plen_d;
    logic        ls_pend_q, ls_pend_d;
    logic        ls_pwr_q, ls_pwr_d;
    logic [31:0] ls_paddr_q, ls_paddr_d;
    logic [1:0]  ls_plen_q, ls_plen_d;
    logic [31:0] ls_pwdata_q, ls_pwdata_d;

    // Registered outputs
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] ls_data_q, ls_data_d;
    logic        if_done_q, if_done_d;
    logic        ls_done_q, ls_done_d;
    logic        if_busy_q, if_busy_d;
    logic        ls_busy_q, ls_busy_d;
    logic [31:0] ram_addr_q, ram_addr_d;
    logic [7:0]  ram_dout_q, ram_dout_d;
    logic        ram_wr_q, ram_wr_d;

    // Combinational helpers
    logic        if_svc, ls_svc;
    logic        if_new, ls_new;
    logic        st_go, st_ls, st_wr;
    logic [31:0] st_addr, st_wdata;
    logic [1:0]  st_len;
    logic [1:0]  rd_idx, wr_idx;
    logic [2:0]  last_cnt;

    assign if_data   = if_data_q;
    assign ls_data   = ls_data_q;
    assign if_done   = if_done_q;
    assign ls_done   = ls_done_q;
    assign if_busy   = if_busy_q;
    assign ls_busy   = ls_busy_q;
    assign ram_addr  = ram_addr_q;
    assign ram_dout  = ram_dout_q;
    assign ram_wr    = ram_wr_q;
    assign dbg_state = state_q;

    // Next-state logic: request capture, arbitration and byte sequencing
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        port_d      = port_q;
        len_d       = len_q;
        wdata_d     = wdata_q;
        buf_d       = buf_q;
        if_pend_d   = if_pend_q;
        if_pwr_d    = if_pwr_q;
        if_paddr_d  = if_paddr_q;
        if_plen_d   = if_plen_q;
        ls_pend_d   = ls_pend_q;
        ls_pwr_d    = ls_pwr_q;
        ls_paddr_d  = ls_paddr_q;
        ls_plen_d   = ls_plen_q;
        ls_pwdata_d = ls_pwdata_q;
        if_data_d   = if_data_q;
        ls_data_d   = ls_data_q;
        if_done_d   = 1'b0;
        ls_done_d   = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_dout_d  = ram_dout_q;
        ram_wr_d    = ram_wr_q;
        st_go       = 1'b0;
        st_ls       = 1'b0;
        st_wr       = 1'b0;
        st_addr     = 32'h0;
        st_wdata    = 32'h0;
        st_len      = 2'd0;
        rd_idx      = cnt_q[1:0] - 2'd1;
        wr_idx      = cnt_q[1:0] + 2'd1;
        last_cnt    = {1'b0, len_q} + 3'd1;

        if_svc = (state_q != S_IDLE) && !port_q;
        ls_svc = (state_q != S_IDLE) && port_q;
        // A port already holding or running a request ignores new pulses.
        if_new = (if_rw_flag != 2'b00) && !if_pend_q && !if_svc;
        ls_new = (ls_rw_flag != 2'b00) && !ls_pend_q && !ls_svc;

        if (if_new) begin
            if_pend_d  = 1'b1;
            if_pwr_d   = if_rw_flag[1];
            if_paddr_d = if_addr;
            if_plen_d  = if_len;
        end
        if (ls_new) begin
            ls_pend_d   = 1'b1;
            ls_pwr_d    = ls_rw_flag[1];
            ls_paddr_d  = ls_addr;
            ls_plen_d   = ls_len;
            ls_pwdata_d = ls_wdata;
        end

        case (state_q)
            S_IDLE: begin
                ram_wr_d = 1'b0;
                // LS wins; a request arriving this edge can start immediately.
                if (ls_pend_q || ls_new) begin
                    st_go     = 1'b1;
                    st_ls     = 1'b1;
                    st_wr     = ls_pend_q ? ls_pwr_q    : ls_rw_flag[1];
                    st_addr   = ls_pend_q ? ls_paddr_q  : ls_addr;
                    st_len    = ls_pend_q ? ls_plen_q   : ls_len;
                    st_wdata  = ls_pend_q ? ls_pwdata_q : ls_wdata;
                    ls_pend_d = 1'b0;
                end else if (if_pend_q || if_new) begin
                    st_go     = 1'b1;
                    st_ls     = 1'b0;
                    st_wr     = if_pend_q ? if_pwr_q   : if_rw_flag[1];
                    st_addr   = if_pend_q ? if_paddr_q : if_addr;
                    st_len    = if_pend_q ? if_plen_q  : if_len;
                    // The fetch port has no write-data bus; its writes store zeros.
                    st_wdata  = 32'h0;
                    if_pend_d = 1'b0;
                end
                if (st_go) begin
                    state_d    = st_wr ? S_WRITE : S_READ;
                    cnt_d      = 3'd0;
                    port_d     = st_ls;
                    len_d      = st_len;
                    wdata_d    = st_wdata;
                    buf_d      = 32'h0;
                    ram_addr_d = st_addr;
                    if (st_wr) begin
                        ram_wr_d   = 1'b1;
                        ram_dout_d = st_wdata[7:0];
                    end
                end
            end

            S_READ: begin
                // cnt_q counts edges since start; byte cnt_q-1 is on ram_din now.
                cnt_d = cnt_q + 3'd1;
                if (cnt_q != 3'd0) begin
                    buf_d[{rd_idx, 3'b000} +: 8] = ram_din;
                end
                if (cnt_q < {1'b0, len_q}) begin
                    ram_addr_d = ram_addr_q + 32'd1;
                end
                if (cnt_q == last_cnt) begin
                    state_d = S_IDLE;
                    cnt_d   = 3'd0;
                    if (port_q) begin
                        ls_data_d = buf_d;
                        ls_done_d = 1'b1;
                    end else begin
                        if_data_d = buf_d;
                        if_done_d = 1'b1;
                    end
                end
            end

            S_WRITE: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q < {1'b0, len_q}) begin
                    ram_wr_d   = 1'b1;
                    ram_addr_d = ram_addr_q + 32'd1;
                    ram_dout_d = wdata_q[{wr_idx, 3'b000} +: 8];
                end else begin
                    ram_wr_d = 1'b0;
                    state_d  = S_IDLE;
                    cnt_d    = 3'd0;
                    if (port_q) begin
                        ls_done_d = 1'b1;
                    end else begin
                        if_done_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d  = S_IDLE;
                cnt_d    = 3'd0;
                ram_wr_d = 1'b0;
            end
        endcase

        if_busy_d = if_pend_d || ((state_d != S_IDLE) && !port_d);
        ls_busy_d = ls_pend_d || ((state_d != S_IDLE) && port_d);
    end

    // State registers; rdy=0 freezes everything, reset aborts any transfer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            port_q      <= 1'b0;
            len_q       <= 2'd0;
            wdata_q     <= 32'h0;
            buf_q       <= 32'h0;
            if_pend_q   <= 1'b0;
            if_pwr_q    <= 1'b0;
            if_paddr_q  <= 32'h0;
            if_plen_q   <= 2'd0;
            ls_pend_q   <= 1'b0;
            ls_pwr_q    <= 1'b0;
            ls_paddr_q  <= 32'h0;
            ls_plen_q   <= 2'd0;
            ls_pwdata_q <= 32'h0;
            if_data_q   <= 32'h0;
            ls_data_q   <= 32'h0;
            if_done_q   <= 1'b0;
            ls_done_q   <= 1'b0;
            if_busy_q   <= 1'b0;
            ls_busy_q   <= 1'b0;
            ram_addr_q  <= 32'h0;
            ram_dout_q  <= 8'h0;
            ram_wr_q    <= 1'b0;
        end else if (rdy) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            port_q      <= port_d;
            len_q       <= len_d;
            wdata_q     <= wdata_d;
            buf_q       <= buf_d;
            if_pend_q   <= if_pend_d;
            if_pwr_q    <= if_pwr_d;
            if_paddr_q  <= if_paddr_d;
            if_plen_q   <= if_plen_d;
            ls_pend_q   <= ls_pend_d;
            ls_pwr_q    <= ls_pwr_d;
            ls_paddr_q  <= ls_paddr_d;
            ls_plen_q   <= ls_plen_d;
            ls_pwdata_q <= ls_pwdata_d;
            if_data_q   <= if_data_d;
            ls_data_q   <= ls_data_d;
            if_done_q   <= if_done_d;
            ls_done_q   <= ls_done_d;
            if_busy_q   <= if_busy_d;
            ls_busy_q   <= ls_busy_d;
            ram_addr_q  <= ram_addr_d;
            ram_dout_q  <= ram_dout_d;
            ram_wr_q    <= ram_wr_d;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM model, table-driven transfers, then
// hand-written sequences for latency, arbitration, stall, reset abort and
// dropped requests. Results are checked through per-port expected queues.
module tb_mem_ctrl;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  if_rw_flag = 2'b00;
    logic [31:0] if_addr = 32'h0;
    logic [1:0]  if_len = 2'd0;
    logic [31:0] if_data;
    logic        if_busy, if_done;
    logic [1:0]  ls_rw_flag = 2'b00;
    logic [31:0] ls_addr = 32'h0;
    logic [1:0]  ls_len = 2'd0;
    logic [31:0] ls_wdata = 32'h0;
    logic [31:0] ls_data;
    logic        ls_busy, ls_done;
    logic [7:0]  ram_din = 8'h0;
    logic [7:0]  ram_dout;
    logic [31:0] ram_addr;
    logic        ram_wr;
    logic [1:0]  dbg_state;

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_rw_flag(if_rw_flag), .if_addr(if_addr), .if_len(if_len),
        .if_data(if_data), .if_busy(if_busy), .if_done(if_done),
        .ls_rw_flag(ls_rw_flag), .ls_addr(ls_addr), .ls_len(ls_len),
        .ls_wdata(ls_wdata), .ls_data(ls_data), .ls_busy(ls_busy),
        .ls_done(ls_done), .ram_din(ram_din), .ram_dout(ram_dout),
        .ram_addr(ram_addr), .ram_wr(ram_wr), .dbg_state(dbg_state)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic adv = 1'b0;          // the most recent edge had rdy=1
    int if_done_cnt = 0;
    int ls_done_cnt = 0;
    int last_if_done_cyc = 0;
    int last_ls_done_cyc = 0;
    int issue_cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        adv <= rdy;
    end

    // ---------------- RAM model and bench-side shadow ----------------
    logic [7:0] ram_mem [logic [31:0]];
    logic [7:0] shadow  [logic [31:0]];

    function automatic logic [7:0] pat(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] shadow_rd(input logic [31:0] a);
        return shadow.exists(a) ? shadow[a] : pat(a);
    endfunction

    always @(posedge clk) begin
        if (rdy) begin
            ram_din <= ram_mem.exists(ram_addr) ? ram_mem[ram_addr] : pat(ram_addr);
            if (ram_wr) ram_mem[ram_addr] = ram_dout;
        end
    end

    // ---------------- scoreboard ----------------
    logic [31:0] exp_if_q[$];
    logic [31:0] exp_ls_q[$];
    logic [39:0] exp_wr_q[$];
    logic [31:0] if_last = 32'h0;
    logic [31:0] ls_last = 32'h0;
    logic [31:0] e_mon;
    logic [39:0] w_mon;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst && adv) begin
            if (if_done) begin
                if_done_cnt++;
                last_if_done_cyc = cyc;
                checks++;
                if (exp_if_q.size() == 0) begin
                    failures++;
                    $display("FAIL if_done_unexpected actual=%h required=none", if_data);
                end else begin
                    e_mon = exp_if_q.pop_front();
                    if (if_data !== e_mon) begin
                        failures++;
                        $display("FAIL if_data actual=%h required=%h", if_data, e_mon);
                    end
                end
            end
            if (ls_done) begin
                ls_done_cnt++;
                last_ls_done_cyc = cyc;
                checks++;
                if (exp_ls_q.size() == 0) begin
                    failures++;
                    $display("FAIL ls_done_unexpected actual=%h required=none", ls_data);
                end else begin
                    e_mon = exp_ls_q.pop_front();
                    if (ls_data !== e_mon) begin
                        failures++;
                        $display("FAIL ls_data actual=%h required=%h", ls_data, e_mon);
                    end
                end
            end
            if (ram_wr) begin
                checks++;
                if (exp_wr_q.size() == 0) begin
                    failures++;
                    $display("FAIL ram_write_unexpected actual=%h/%h required=none", ram_addr, ram_dout);
                end else begin
                    w_mon = exp_wr_q.pop_front();
                    if ({ram_addr, ram_dout} !== w_mon) begin
                        failures++;
                        $display("FAIL ram_write actual=%h/%h required=%h/%h",
                                 ram_addr, ram_dout, w_mon[39:8], w_mon[7:0]);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_exp(input logic ls, input logic wr, input logic [31:0] addr,
                            input logic [1:0] len, input logic [31:0] wdata,
                            input logic use_exp, input logic [31:0] exp_v);
        logic [31:0] v;
        logic [31:0] a;
        v = 32'h0;
        if (wr) begin
            for (int k = 0; k <= int'(len); k++) begin
                a = addr + 32'(k);
                shadow[a] = wdata[8*k +: 8];
                exp_wr_q.push_back({a, wdata[8*k +: 8]});
            end
            v = ls ? ls_last : if_last;
        end else begin
            for (int k = 0; k <= int'(len); k++) begin
                v[8*k +: 8] = shadow_rd(addr + 32'(k));
            end
        end
        if (use_exp) v = exp_v;
        if (!wr) begin
            if (ls) ls_last = v;
            else    if_last = v;
        end
        if (ls) exp_ls_q.push_back(v);
        else    exp_if_q.push_back(v);
    endtask

    task automatic drive(input logic ls, input logic wr, input logic [31:0] addr,
                         input logic [1:0] len, input logic [31:0] wdata);
        if (ls) begin
            ls_rw_flag = wr ? 2'b10 : 2'b01;
            ls_addr    = addr;
            ls_len     = len;
            ls_wdata   = wdata;
        end else begin
            if_rw_flag = wr ? 2'b10 : 2'b01;
            if_addr    = addr;
            if_len     = len;
        end
    endtask

    task automatic clear_req();
        if_rw_flag = 2'b00;
        ls_rw_flag = 2'b00;
    endtask

    task automatic issue(input logic ls, input logic wr, input logic [31:0] addr,
                         input logic [1:0] len, input logic [31:0] wdata,
                         input logic use_exp, input logic [31:0] exp_v);
        push_exp(ls, wr, addr, len, wdata, use_exp, exp_v);
        drive(ls, wr, addr, len, wdata);
        issue_cyc = cyc;
        step();
        clear_req();
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((exp_if_q.size() != 0 || exp_ls_q.size() != 0 || exp_wr_q.size() != 0 ||
                if_busy || ls_busy) && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL wait_idle_timeout actual=%0d cycles required=<%0d", n, budget);
        end
        step();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ram_addr"}, ram_addr, 32'h0);
        chk({tag, "_ram_dout"}, {24'h0, ram_dout}, 32'h0);
        chk({tag, "_ram_wr"}, {31'h0, ram_wr}, 32'h0);
        chk({tag, "_if_data"}, if_data, 32'h0);
        chk({tag, "_ls_data"}, ls_data, 32'h0);
        chk({tag, "_flags"}, {28'h0, if_busy, if_done, ls_busy, ls_done}, 32'h0);
        chk({tag, "_state"}, {30'h0, dbg_state}, 32'h0);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic        ls;
        logic        wr;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] wdata;
        logic [31:0] exp_v;   // data output expected at done
    } vec_t;

    vec_t tbl[9];

    initial begin : main
        int n0;
        int ls_c;
        int if_c;
        logic rl;
        logic rw;
        tbl[0] = '{1'b0, 1'b0, 32'h0000_0100, 2'd3, 32'h0,         32'h0000_0513};
        tbl[1] = '{1'b1, 1'b1, 32'h0003_0004, 2'd0, 32'h0000_00AB, 32'h0};
        tbl[2] = '{1'b1, 1'b0, 32'h0003_0004, 2'd0, 32'h0,         32'h0000_00AB};
        tbl[3] = '{1'b1, 1'b0, 32'h0003_0004, 2'd3, 32'h0,         32'h5E5F_5CAB};
        tbl[4] = '{1'b1, 1'b1, 32'h0004_0000, 2'd2, 32'h00C0_FFEE, 32'h5E5F_5CAB};
        tbl[5] = '{1'b0, 1'b0, 32'h0004_0000, 2'd3, 32'h0,         32'h5DC0_FFEE};
        tbl[6] = '{1'b1, 1'b1, 32'hFFFF_FFFE, 2'd3, 32'h1122_3344, 32'h5E5F_5CAB};
        tbl[7] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 2'd1, 32'h0,         32'h0000_2233};
        tbl[8] = '{1'b1, 1'b0, 32'h0000_0000, 2'd2, 32'h0,         32'h0058_1122};

        // instruction bytes at 0x100: addi a0,x0,0 (0x00000513)
        ram_mem[32'h100] = 8'h13; ram_mem[32'h101] = 8'h05;
        ram_mem[32'h102] = 8'h00; ram_mem[32'h103] = 8'h00;
        shadow[32'h100]  = 8'h13; shadow[32'h101]  = 8'h05;
        shadow[32'h102]  = 8'h00; shadow[32'h103]  = 8'h00;

        // reset state
        step(); step(); step();
        chk_all_zero("reset");
        rst = 1'b1;
        step();

        // table-driven transfers
        for (int i = 0; i < 9; i++) begin
            issue(tbl[i].ls, tbl[i].wr, tbl[i].addr, tbl[i].len, tbl[i].wdata, 1'b1, tbl[i].exp_v);
            wait_idle(40);
        end

        // IF read latency: done visible after edge E+5
        issue(1'b0, 1'b0, 32'h100, 2'd3, 32'h0, 1'b1, 32'h0000_0513);
        n0 = issue_cyc;
        wait_idle(40);
        chk("if_read_latency", last_if_done_cyc - n0, 32'd6);

        // LS single-byte write latency: done after edge E+1
        issue(1'b1, 1'b1, 32'h0003_0004, 2'd0, 32'h0000_00AB, 1'b0, 32'h0);
        n0 = issue_cyc;
        wait_idle(40);
        chk("ls_write_latency", last_ls_done_cyc - n0, 32'd2);

        // simultaneous IF and LS reads: LS first, IF starts right after
        push_exp(1'b1, 1'b0, 32'h1000, 2'd3, 32'h0, 1'b0, 32'h0);
        push_exp(1'b0, 1'b0, 32'h0,    2'd3, 32'h0, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 32'h1000, 2'd3, 32'h0);
        drive(1'b0, 1'b0, 32'h0,    2'd3, 32'h0);
        n0 = cyc;
        step();
        clear_req();
        wait_idle(60);
        chk("both_ls_latency", last_ls_done_cyc - n0, 32'd6);
        chk("both_if_latency", last_if_done_cyc - n0, 32'd12);

        // IF read arriving during a 4-byte LS write waits for it
        issue(1'b1, 1'b1, 32'h2000, 2'd3, 32'hDEAD_BEEF, 1'b0, 32'h0);
        n0 = issue_cyc;
        issue(1'b0, 1'b0, 32'h2000, 2'd3, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        chk("during_write_if_busy", {31'h0, if_busy}, 32'h1);
        chk("during_write_ram_wr", {31'h0, ram_wr}, 32'h1);
        wait_idle(60);
        chk("during_write_ls_done", last_ls_done_cyc - n0, 32'd5);
        chk("during_write_if_done", last_if_done_cyc - n0, 32'd11);

        // rdy low stalls a read and blocks request capture
        issue(1'b1, 1'b0, 32'h0003_0004, 2'd3, 32'h0, 1'b0, 32'h0);
        step();
        rdy = 1'b0;
        drive(1'b0, 1'b0, 32'h9, 2'd0, 32'h0);
        step(); step(); step();
        chk("stall_ram_addr", ram_addr, 32'h0003_0005);
        chk("stall_if_busy", {31'h0, if_busy}, 32'h0);
        chk("stall_ls_busy", {31'h0, ls_busy}, 32'h1);
        clear_req();
        rdy = 1'b1;
        wait_idle(60);

        // reset in cycle 3 of a 4-byte read aborts it
        if_c = if_done_cnt;
        issue(1'b0, 1'b0, 32'h100, 2'd3, 32'h0, 1'b0, 32'h0);
        step(); step();
        rst = 1'b0;
        #1;
        chk_all_zero("abort");
        exp_if_q.delete();
        exp_wr_q.delete();
        if_last = 32'h0;
        ls_last = 32'h0;
        drive(1'b0, 1'b0, 32'h100, 2'd3, 32'h0);   // dropped while in reset
        step(); step();
        clear_req();
        rst = 1'b1;
        step();
        chk("post_reset_if_busy", {31'h0, if_busy}, 32'h0);
        for (int i = 0; i < 8; i++) step();
        chk("post_reset_no_done", if_done_cnt - if_c, 32'd0);
        issue(1'b0, 1'b0, 32'h100, 2'd3, 32'h0, 1'b1, 32'h0000_0513);
        wait_idle(40);

        // second IF request while busy is ignored
        if_c = if_done_cnt;
        issue(1'b0, 1'b0, 32'h2000, 2'd3, 32'h0, 1'b1, 32'hDEAD_BEEF);
        drive(1'b0, 1'b0, 32'h100, 2'd3, 32'h0);
        step();
        clear_req();
        wait_idle(40);
        for (int i = 0; i < 10; i++) step();
        chk("ignored_single_done", if_done_cnt - if_c, 32'd1);

        // random traffic against the shadow model
        ls_c = ls_done_cnt;
        for (int i = 0; i < 8; i++) begin
            rl = 1'($urandom_range(0, 1));
            rw = rl ? 1'($urandom_range(0, 1)) : 1'b0;
            issue(rl, rw, 32'h5000 + 32'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                  $urandom, 1'b0, 32'h0);
            wait_idle(40);
        end
        chk("random_done_count", (ls_done_cnt - ls_c) + (if_done_cnt - if_c - 1), 32'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout actual=%0t required=<400000", $time);
        $fatal(1);
    end

endmodule
